// File: rtl/johnson_step_controller_if.sv
// Step-command channel for johnson_step_controller.
// Valid/ready handshake with the command payload.
interface johnson_step_controller_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int DIV_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_steps;
  logic             cmd_dir;
  logic [DIV_W-1:0] cmd_div;
  logic             cmd_load;
  logic [WIDTH-1:0] cmd_phase;

  modport master (
    output cmd_valid,
    output cmd_steps,
    output cmd_dir,
    output cmd_div,
    output cmd_load,
    output cmd_phase,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_steps,
    input  cmd_dir,
    input  cmd_div,
    input  cmd_load,
    input  cmd_phase,
    output cmd_ready
  );
endinterface

// File: rtl/johnson_step_controller.sv
// Johnson phase sequencer: prescaled fwd/rev stepping,
// preload with legality check, abort and completion pulse.
module johnson_step_controller #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int DIV_W = 8
) (
  input  logic             Clk,
  input  logic             Clr,
  johnson_step_controller_if.slave cmd,
  input  logic             abort,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             err,
  output logic [CNT_W-1:0] steps_left
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] q_r, q_n;
  logic             dir_r, dir_n;
  logic [DIV_W-1:0] div_r, div_n;
  logic [DIV_W-1:0] psc_r, psc_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic             abt_r, abt_n;
  logic             err_r, err_n;

  logic             accept;
  logic             tick;
  logic             legal;
  logic [WIDTH-1:0] q_fwd;
  logic [WIDTH-1:0] q_rev;

  // legal codes: k ones from the MSB, or their complement
  function automatic logic is_legal(
    input logic [WIDTH-1:0] p
  );
    logic [WIDTH-1:0] m;
    logic             ok;
    ok = 1'b0;
    for (int k = 0; k <= WIDTH; k++) begin
      m = ~({WIDTH{1'b1}} >> k);
      if (p == m || p == ~m)
        ok = 1'b1;
    end
    return ok;
  endfunction

  assign cmd.cmd_ready = (state == IDLE);
  assign busy          = (state == RUN);
  assign done          = (state == DONE);
  assign Q             = q_r;
  assign aborted       = abt_r;
  assign err           = err_r;
  assign steps_left    = cnt_r;

  assign accept = cmd.cmd_valid && (state == IDLE);
  assign tick   = (state == RUN) && (psc_r == div_r);
  assign legal  = is_legal(cmd.cmd_phase);
  assign q_fwd  = {~q_r[0], q_r[WIDTH-1:1]};
  assign q_rev  = {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state <= IDLE;
      q_r   <= '0;
      dir_r <= 1'b0;
      div_r <= '0;
      psc_r <= '0;
      cnt_r <= '0;
      abt_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      state <= state_n;
      q_r   <= q_n;
      dir_r <= dir_n;
      div_r <= div_n;
      psc_r <= psc_n;
      cnt_r <= cnt_n;
      abt_r <= abt_n;
      err_r <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    q_n     = q_r;
    dir_n   = dir_r;
    div_n   = div_r;
    psc_n   = psc_r;
    cnt_n   = cnt_r;
    abt_n   = abt_r;
    err_n   = err_r;
    unique case (1'b1)
      (state == IDLE): begin
        if (accept) begin
          dir_n = cmd.cmd_dir;
          div_n = cmd.cmd_div;
          cnt_n = cmd.cmd_steps;
          psc_n = '0;
          abt_n = 1'b0;
          err_n = 1'b0;
          if (cmd.cmd_load) begin
            if (legal) begin
              q_n = cmd.cmd_phase;
            end else begin
              q_n   = '0;
              err_n = 1'b1;
            end
          end
          if (cmd.cmd_steps == '0)
            state_n = DONE;
          else
            state_n = RUN;
        end
      end
      (state == RUN): begin
        // abort wins over a coincident tick
        if (abort) begin
          abt_n   = 1'b1;
          state_n = DONE;
        end else if (tick) begin
          psc_n = '0;
          q_n   = dir_r ? q_fwd : q_rev;
          cnt_n = cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1))
            state_n = DONE;
        end else begin
          psc_n = psc_r + DIV_W'(1);
        end
      end
      (state == DONE): begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_johnson_step_controller.sv
// Scoreboard bench for johnson_step_controller against
// a phase-index reference model.
module tb_johnson_step_controller;
  localparam int W  = 4;
  localparam int CW = 8;
  localparam int DW = 8;
  localparam int NP = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          abort;
  logic [W-1:0]  q;
  logic          busy, done, aborted, err;
  logic [CW-1:0] steps_left;

  always #5 clk = ~clk;

  johnson_step_controller_if #(
    .WIDTH(W), .CNT_W(CW), .DIV_W(DW)
  ) cif ();

  johnson_step_controller #(
    .WIDTH(W), .CNT_W(CW), .DIV_W(DW)
  ) dut (
    .Clk(clk),
    .Clr(rst_n),
    .cmd(cif),
    .abort(abort),
    .Q(q),
    .busy(busy),
    .done(done),
    .aborted(aborted),
    .err(err),
    .steps_left(steps_left)
  );

  typedef struct {
    logic [W-1:0] q;
    int           sl;
    int           ab;
    int           er;
    int           at;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   m_idx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // phase index n: n ones entering from the MSB, then zeros
  function automatic logic [W-1:0] code(input int n);
    logic [W-1:0] c;
    int           m;
    m = ((n % NP) + NP) % NP;
    c = '0;
    for (int b = 0; b < W; b++) begin
      if (m <= W) c[W-1-b] = (b < m);
      else        c[W-1-b] = (b >= m - W);
    end
    return c;
  endfunction

  function automatic int idx_of(input logic [W-1:0] p);
    for (int n = 0; n < NP; n++)
      if (code(n) == p) return n;
    return -1;
  endfunction

  task automatic check(input string nm, input int act,
                       input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      if (sbq.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sbq.pop_front();
        check("done_q", int'(q), int'(e.q));
        check("done_steps_left", int'(steps_left), e.sl);
        check("done_aborted", int'(aborted), e.ab);
        check("done_err", int'(err), e.er);
        check("done_cycle", cyc, e.at);
        check("ready_in_done", int'(cif.cmd_ready), 0);
        check("busy_in_done", int'(busy), 0);
      end
    end
  end

  task automatic issue(input int steps, input bit dir,
                       input int div, input bit load,
                       input logic [W-1:0] phase,
                       input int abort_at, input bit keep,
                       output int acc);
    int   guard;
    int   taken;
    int   i;
    exp_t e;
    @(negedge clk);
    cif.cmd_valid = 1'b1;
    cif.cmd_steps = CW'(steps);
    cif.cmd_dir   = dir;
    cif.cmd_div   = DW'(div);
    cif.cmd_load  = load;
    cif.cmd_phase = phase;
    guard = 0;
    while (!cif.cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      check("accept_timeout", 0, 1);
      cif.cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    if (!keep) cif.cmd_valid = 1'b0;
    e.er = 0;
    if (load) begin
      i = idx_of(phase);
      if (i < 0) begin
        m_idx = 0;
        e.er  = 1;
      end else begin
        m_idx = i;
      end
    end
    taken = (abort_at > 0) ? abort_at - 1 : steps;
    m_idx = (((m_idx + (dir ? taken : -taken)) % NP) + NP) % NP;
    e.q  = code(m_idx);
    e.sl = steps - taken;
    e.ab = (abort_at > 0) ? 1 : 0;
    if (steps == 0)
      e.at = acc;
    else
      e.at = acc + (div + 1) *
             ((abort_at > 0) ? abort_at : steps);
    sbq.push_back(e);
    if (abort_at > 0) begin
      repeat ((div + 1) * abort_at - 1) @(posedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!cif.cmd_ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) check("idle_timeout", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, acc2, s0;
    int st, dv, ab;
    bit dr, ld;
    logic [W-1:0] ph;
    exp_t dummy;

    abort         = 1'b0;
    cif.cmd_valid = 1'b0;
    cif.cmd_steps = '0;
    cif.cmd_dir   = 1'b0;
    cif.cmd_div   = '0;
    cif.cmd_load  = 1'b0;
    cif.cmd_phase = '0;
    repeat (2) @(negedge clk);
    check("rst_q", int'(q), 0);
    check("rst_ready", int'(cif.cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_flags", int'({aborted, err}), 0);
    rst_n = 1'b1;

    // async clear in the middle of a run
    issue(20, 1'b1, 3, 1'b1, 4'b1110, 0, 1'b0, acc);
    dummy = sbq.pop_back();
    check("preload_q", int'(q), 4'b1110);
    repeat (6) @(posedge clk);
    #2;
    check("mid_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("clr_q", int'(q), 0);
    check("clr_busy", int'(busy), 0);
    check("clr_ready", int'(cif.cmd_ready), 1);
    check("clr_steps_left", int'(steps_left), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_idx = 0;

    // full forward revolution, one step per edge
    s0 = m_idx;
    issue(8, 1'b1, 0, 1'b0, '0, 0, 1'b0, acc);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      check("fwd_trace", int'(q), int'(code(s0 + k)));
    end
    wait_idle();
    check("ready_after_done", int'(cif.cmd_ready), 1);

    // reverse with prescale and preload
    issue(3, 1'b0, 2, 1'b1, 4'b1100, 0, 1'b0, acc);
    check("load_q", int'(q), 4'b1100);
    repeat (2) @(posedge clk);
    #1;
    check("psc_hold", int'(q), 4'b1100);
    @(posedge clk);
    #1;
    check("rev_step1", int'(q), 4'b1000);
    wait_idle();

    // illegal preload
    issue(1, 1'b1, 0, 1'b1, 4'b0100, 0, 1'b0, acc);
    check("ill_err", int'(err), 1);
    check("ill_q", int'(q), 0);
    wait_idle();
    check("err_sticky", int'(err), 1);
    issue(2, 1'b1, 1, 1'b0, '0, 0, 1'b0, acc);
    check("err_cleared", int'(err), 0);
    wait_idle();

    // abort coincident with 4th tick
    issue(0, 1'b0, 0, 1'b1, 4'b0000, 0, 1'b0, acc);
    wait_idle();
    issue(10, 1'b1, 0, 1'b0, '0, 4, 1'b0, acc);
    wait_idle();
    check("abort_q", int'(q), 4'b1110);
    check("abort_left", int'(steps_left), 7);

    // zero steps, valid held through DONE
    issue(0, 1'b1, 0, 1'b0, '0, 0, 1'b1, acc);
    @(negedge clk);
    check("zero_busy", int'(busy), 0);
    issue(2, 1'b0, 0, 1'b0, '0, 0, 1'b0, acc2);
    check("held_accept_gap", acc2 - acc, 2);
    wait_idle();

    for (int n = 0; n < 40; n++) begin
      st = $urandom_range(0, 20);
      dr = 1'($urandom_range(0, 1));
      dv = $urandom_range(0, 3);
      ld = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1)
        ph = code($urandom_range(0, NP - 1));
      else
        ph = W'($urandom);
      ab = 0;
      if (st > 0 && $urandom_range(0, 3) == 0)
        ab = $urandom_range(1, st);
      issue(st, dr, dv, ld, ph, ab, 1'b0, acc);
      wait_idle();
    end

    repeat (4) @(negedge clk);
    check("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule

// File: doc/johnson_step_controller.md
Name: johnson_step_controller

Overview:
Command-driven sequencer for a WIDTH-bit Johnson (twisted-ring) phase register, producing 2*WIDTH distinct phase codes. It accepts step commands over a valid/ready handshake, advances the phase forward or backward at a programmable prescaled rate, supports phase preload and abort, and reports completion. It sits between the control logic and phase-driven loads such as stepper drivers or multiphase strobes.

Parameters:
WIDTH, 4, Johnson register width; 2*WIDTH legal phase codes
CNT_W, 8, width of step count
DIV_W, 8, width of prescaler divide value

Ports:
Clk  input  1  clock, rising-edge active
Clr  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_steps  input  CNT_W  number of steps to execute
cmd_dir  input  1  1 = forward, 0 = reverse
cmd_div  input  DIV_W  one step every cmd_div+1 clocks
cmd_load  input  1  preload phase from cmd_phase at accept
cmd_phase  input  WIDTH  preload phase value
abort  input  1  terminate running command
Q  output  WIDTH  current Johnson phase
busy  output  1  command in progress (RUN state)
done  output  1  one-cycle completion pulse
aborted  output  1  last command ended by abort (sticky until next accept)
err  output  1  illegal preload detected (sticky until next accept)
steps_left  output  CNT_W  remaining steps

Behaviour:
- Clr low, asynchronous: Q=0, state IDLE, cmd_ready=1, busy=0, done=0, aborted=0, err=0, steps_left=0, prescaler=0. Applies mid-command; command is discarded.
- States: IDLE, RUN, DONE. cmd_ready=1 only in IDLE. busy=1 only in RUN. done=1 only in DONE.
- Accept when cmd_valid&&cmd_ready at an edge: latch dir and div; steps_left<=cmd_steps; clear err and aborted; prescaler<=0.
- cmd_steps=0: accepted, go directly to DONE, no step taken.
- Otherwise go to RUN.
- Preload: if cmd_load=1 at accept, Q<=cmd_phase when legal. Legal codes are 1^k0^(WIDTH-k) or 0^k1^(WIDTH-k), k=0..WIDTH. An illegal cmd_phase sets Q<=0 and err<=1, and the command still runs.
- RUN: the prescaler counts 0..div. A tick occurs at the edge where prescaler==div; the prescaler then resets to 0. The first step falls div+1 edges after accept.
- Forward tick: Q<={~Q[0],Q[WIDTH-1:1]}. Reverse tick: Q<={Q[WIDTH-2:0],~Q[WIDTH-1]}. Each tick decrements steps_left by 1.
- Tick that brings steps_left to 0: next state DONE.
- Wrap-around: after 2*WIDTH steps in either direction, Q returns to its start code. Counts larger than 2*WIDTH wrap repeatedly.
- abort=1 in RUN: next state DONE with aborted<=1 and steps_left held. Abort has priority over a coincident tick; no step is taken that cycle. abort is ignored in IDLE and DONE.
- DONE lasts exactly one cycle, then IDLE. A command presented during DONE waits; it is accepted in IDLE the following cycle.
- Q holds its value in IDLE and DONE. cmd_* inputs are ignored except at accept.

Test Plan:
1. Reset with Q preloaded to 1110, then Clr=0 mid-RUN -> Q=0000, busy=0, cmd_ready=1, steps_left=0 immediately (before next edge).
2. WIDTH=4; accept steps=8, dir=1, div=0 from Q=0000 -> Q on edges 1..8 = 1000,1100,1110,1111,0111,0011,0001,0000; done=1 for one cycle after edge 8; cmd_ready=1 the cycle after.
3. Accept steps=3, dir=0, div=2, load=1, phase=1100 -> Q=1100 after accept; steps at edges 3,6,9: 1000,0000,0001; done one cycle after edge 9.
4. Accept load=1, phase=0100, steps=1, dir=1, div=0 -> err=1, Q=0000, then Q=1000; err holds until the next accept, which clears it.
5. Accept steps=10, div=0; assert abort coincident with the 4th tick -> Q shows only 3 steps (1110 from 0000), steps_left=7, aborted=1, done pulse, return to IDLE.
6. Accept steps=0 -> done the next cycle, Q unchanged, busy never asserted; cmd_valid held through DONE -> second command accepted in IDLE one cycle later.
